// File: rtl/ram8_arbiter_if.sv
// Bundle of the two requester ports and the ram8 pins owned by ram8_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and ram8's view.
interface ram8_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [DATA_W-1:0] ram_out;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        input  ram_out,
        output ram_address, ram_in, ram_load, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        output ram_out,
        input  ram_address, ram_in, ram_load, busy
    );
endinterface

// File: rtl/ram8_arbiter.sv
// Round-robin two-requester sequencer in front of a ram8 register file (IDLE -> SERVE -> ACK).
// Define RAM8_ARBITER_CLEAR_EN to add a post-reset CLEAR sweep that zeroes all eight words.
module ram8_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    ram8_arbiter_if.slave  bus
);

`ifdef RAM8_ARBITER_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, ACK = 2'd2, CLEAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, ACK = 2'd2} state_t;
`endif

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;   // 1 = B holds the most recent grant
    logic              win_b_q, win_b_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;       // doubles as the ram8 address register
    logic [DATA_W-1:0] wdata_q, wdata_d;     // doubles as the ram8 data-in register
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
`ifdef RAM8_ARBITER_CLEAR_EN
    logic              clr_pend_q, clr_pend_d;
`endif

    logic grant_b;
    logic ram_load_c;
    logic a_ack_c;
    logic b_ack_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            win_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef RAM8_ARBITER_CLEAR_EN
            clr_pend_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            win_b_q   <= win_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifdef RAM8_ARBITER_CLEAR_EN
            clr_pend_q <= clr_pend_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        win_b_d    = win_b_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
`ifdef RAM8_ARBITER_CLEAR_EN
        clr_pend_d = clr_pend_q;
`endif
        grant_b    = 1'b0;
        ram_load_c = 1'b0;
        a_ack_c    = 1'b0;
        b_ack_c    = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef RAM8_ARBITER_CLEAR_EN
                // The sweep starts one cycle after reset release so reset itself never writes.
                if (clr_pend_q) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    wdata_d = '0;
                end else
`endif
                if (bus.a_req || bus.b_req) begin
                    // Under contention the requester that did not win last time goes first.
                    grant_b  = bus.b_req && (!bus.a_req || !last_b_q);
                    win_b_d  = grant_b;
                    last_b_d = grant_b;
                    we_d     = grant_b ? bus.b_we    : bus.a_we;
                    addr_d   = grant_b ? bus.b_addr  : bus.a_addr;
                    wdata_d  = grant_b ? bus.b_wdata : bus.a_wdata;
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                ram_load_c = we_q;
                if (!we_q) begin
                    if (win_b_q) b_rdata_d = bus.ram_out;
                    else         a_rdata_d = bus.ram_out;
                end
                state_d = ACK;
            end
            ACK: begin
                a_ack_c = !win_b_q;
                b_ack_c = win_b_q;
                state_d = IDLE;
            end
`ifdef RAM8_ARBITER_CLEAR_EN
            CLEAR: begin
                ram_load_c = 1'b1;
                if (addr_q == '1) begin
                    state_d    = IDLE;
                    clr_pend_d = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.ram_address = addr_q;
    assign bus.ram_in      = wdata_q;
    assign bus.ram_load    = ram_load_c;
    assign bus.a_ack       = a_ack_c;
    assign bus.b_ack       = b_ack_c;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed plus randomized bench for ram8_arbiter with a behavioural ram8 and a transaction-level model.
// Honours RAM8_ARBITER_CLEAR_EN to exercise the post-reset clear sweep.
module tb_ram8_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram8_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus();

    ram8_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural ram8: combinational read, write on the rising edge when load is high.
    logic [15:0] mem [8];
    always @(posedge clk) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    assign bus.ram_out = mem[bus.ram_address];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] ref_mem [8];

    // Transaction-level model state for the randomized phase
    int   free_c, ack_c, serve_c;
    bit   win_b, cur_we, last_b, a_pend, b_pend;
    logic [2:0]  cur_addr;
    logic [15:0] exp_a_rd, exp_b_rd;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks the cycle right after reset release and, with the clear sweep, its 8 cycles.
    task automatic post_reset;
        chk1("rel_busy", bus.busy, 1'b0);
        chk1("rel_a_ack", bus.a_ack, 1'b0);
`ifdef RAM8_ARBITER_CLEAR_EN
        for (int i = 0; i < 8; i++) begin
            tick;
            chk1("clr_busy", bus.busy, 1'b1);
            chk1("clr_load", bus.ram_load, 1'b1);
            chk16("clr_addr", 16'(bus.ram_address), 16'(i));
            chk16("clr_in", bus.ram_in, 16'h0000);
        end
        tick;
        chk1("clr_done_busy", bus.busy, 1'b0);
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
`endif
    endtask

    task automatic do_reset;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        reset = 1'b1;
        #1;
        chk1("rst_a_ack", bus.a_ack, 1'b0);
        chk1("rst_b_ack", bus.b_ack, 1'b0);
        chk1("rst_load", bus.ram_load, 1'b0);
        chk16("rst_addr", 16'(bus.ram_address), 16'h0000);
        chk16("rst_in", bus.ram_in, 16'h0000);
        chk16("rst_a_rdata", bus.a_rdata, 16'h0000);
        chk16("rst_b_rdata", bus.b_rdata, 16'h0000);
        chk1("rst_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        post_reset();
    endtask

    // One uncontended transaction starting in an IDLE cycle; ends in the following IDLE cycle.
    task automatic do_one(input bit who_b, input bit we, input logic [2:0] addr,
                          input logic [15:0] data, input logic [15:0] exp_rd);
        if (who_b) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
        end
        tick;
        chk1("serve_busy", bus.busy, 1'b1);
        chk1("serve_load", bus.ram_load, we);
        chk16("serve_addr", 16'(bus.ram_address), 16'(addr));
        chk1("serve_a_ack", bus.a_ack, 1'b0);
        chk1("serve_b_ack", bus.b_ack, 1'b0);
        tick;
        chk1("ack_a", bus.a_ack, !who_b);
        chk1("ack_b", bus.b_ack, who_b);
        chk1("ack_load", bus.ram_load, 1'b0);
        if (!we) chk16("ack_rdata", who_b ? bus.b_rdata : bus.a_rdata, exp_rd);
        if (we) ref_mem[addr] = data;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        $display("txn %s %s addr=%0d data=%h", who_b ? "B" : "A", we ? "WR" : "RD", addr,
                 we ? data : exp_rd);
        tick;
        chk1("idle_busy", bus.busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Contention right after reset: A must win, B acks three cycles later.
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 3'd1; bus.a_wdata = 16'h1111;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 3'd1; bus.b_wdata = 16'h0000;
        tick;
        chk1("cont_serveA_load", bus.ram_load, 1'b1);
        tick;
        chk1("cont_a_ack", bus.a_ack, 1'b1);
        chk1("cont_b_noack", bus.b_ack, 1'b0);
        bus.a_req = 1'b0;
        ref_mem[1] = 16'h1111;
        $display("txn A WR addr=1 data=1111 (contended)");
        tick;
        chk1("cont_idle_busy", bus.busy, 1'b0);
        tick;
        chk1("cont_serveB_load", bus.ram_load, 1'b0);
        chk1("cont_serveB_ack", bus.b_ack, 1'b0);
        tick;
        chk1("cont_b_ack", bus.b_ack, 1'b1);
        chk1("cont_a_noack", bus.a_ack, 1'b0);
        chk16("cont_b_rdata", bus.b_rdata, 16'h1111);
        bus.b_req = 1'b0;
        $display("txn B RD addr=1 data=%h (contended)", bus.b_rdata);
        tick;

        for (int i = 0; i < 8; i++) do_one(1'b0, 1'b1, 3'(i), 16'hA0A0 + 16'(i), 16'h0000);

        do_one(1'b0, 1'b1, 3'd5, 16'hBEEF, 16'h0000);
        do_one(1'b0, 1'b0, 3'd5, 16'h0000, 16'hBEEF);
        do_one(1'b1, 1'b1, 3'd7, 16'hFFFF, 16'h0000);
        do_one(1'b1, 1'b1, 3'd0, 16'h0001, 16'h0000);
        do_one(1'b1, 1'b0, 3'd7, 16'h0000, 16'hFFFF);
        do_one(1'b1, 1'b0, 3'd0, 16'h0000, 16'h0001);

        // Both hold requests; last grant was B so the sequence is A,B,A,B,A,B.
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 3'd5;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 3'd2;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk1("alt_serve_a", bus.a_ack, 1'b0);
            chk1("alt_serve_b", bus.b_ack, 1'b0);
            tick;
            chk1("alt_a_ack", bus.a_ack, k % 2 == 0);
            chk1("alt_b_ack", bus.b_ack, k % 2 == 1);
            if (k % 2 == 0) chk16("alt_a_rdata", bus.a_rdata, ref_mem[5]);
            else            chk16("alt_b_rdata", bus.b_rdata, ref_mem[2]);
            $display("txn alt %0d winner=%s", k, (k % 2 == 0) ? "A" : "B");
            tick;
            chk1("alt_idle_a", bus.a_ack, 1'b0);
            chk1("alt_idle_b", bus.b_ack, 1'b0);
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick;

        // Reset in the SERVE cycle of an A write to addr 3: write and ack are suppressed.
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 3'd3; bus.a_wdata = 16'h3333;
        tick;
        chk1("mid_serve_load", bus.ram_load, 1'b1);
        reset = 1'b1;
        #1;
        chk1("mid_rst_load", bus.ram_load, 1'b0);
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chk1("mid_rst_a_ack", bus.a_ack, 1'b0);
        bus.a_req = 1'b0;
        @(posedge clk);
        #1;
        chk1("mid_rst_a_ack2", bus.a_ack, 1'b0);
        reset = 1'b0;
        $display("txn A WR addr=3 aborted by reset");
        post_reset();
        do_one(1'b0, 1'b0, 3'd3, 16'h0000, ref_mem[3]);

`ifdef RAM8_ARBITER_CLEAR_EN
        for (int i = 0; i < 8; i++) do_one(1'b0, 1'b1, 3'(i), 16'h5A00 + 16'(i), 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 3'd3;
        chk1("clrq_rel_busy", bus.busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk1("clrq_busy", bus.busy, 1'b1);
            chk16("clrq_addr", 16'(bus.ram_address), 16'(i));
            chk1("clrq_no_ack", bus.a_ack, 1'b0);
        end
        tick;
        chk1("clrq_idle_busy", bus.busy, 1'b0);
        chk1("clrq_idle_ack", bus.a_ack, 1'b0);
        tick;
        chk1("clrq_serve_ack", bus.a_ack, 1'b0);
        tick;
        chk1("clrq_ack", bus.a_ack, 1'b1);
        chk16("clrq_rdata", bus.a_rdata, 16'h0000);
        bus.a_req = 1'b0;
        $display("txn A RD addr=3 data=%h (pending through clear)", bus.a_rdata);
        tick;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) do_one(1'b1, 1'b0, 3'(i), 16'h0000, 16'h0000);
`endif

        // Randomized phase against the transaction-level model.
        do_reset();
        last_b = 1'b1; a_pend = 1'b0; b_pend = 1'b0; win_b = 1'b0; cur_we = 1'b0;
        free_c = 0; ack_c = -10; serve_c = -10; cur_addr = '0;
        exp_a_rd = 16'h0000; exp_b_rd = 16'h0000;
        for (int c = 0; c < 450; c++) begin
            if (c > 0) begin
                chk1("rnd_a_ack", bus.a_ack, c == ack_c && !win_b);
                chk1("rnd_b_ack", bus.b_ack, c == ack_c && win_b);
                chk1("rnd_busy", bus.busy, c == serve_c || c == ack_c);
                chk1("rnd_load", bus.ram_load, c == serve_c && cur_we);
                if (c == serve_c) chk16("rnd_addr", 16'(bus.ram_address), 16'(cur_addr));
                if (c == ack_c) begin
                    chk16("rnd_a_rdata", bus.a_rdata, exp_a_rd);
                    chk16("rnd_b_rdata", bus.b_rdata, exp_b_rd);
                end
            end
            if (a_pend && c == ack_c + 1 && !win_b) a_pend = 1'b0;
            if (b_pend && c == ack_c + 1 && win_b)  b_pend = 1'b0;
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1'b1;
                bus.a_we = 1'($urandom_range(0, 1));
                bus.a_addr = 3'($urandom_range(0, 7));
                bus.a_wdata = 16'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) != 0) begin
                b_pend = 1'b1;
                bus.b_we = 1'($urandom_range(0, 1));
                bus.b_addr = 3'($urandom_range(0, 7));
                bus.b_wdata = 16'($urandom);
            end
            bus.a_req = a_pend;
            bus.b_req = b_pend;
            if (c >= free_c && (a_pend || b_pend)) begin
                win_b    = b_pend && (!a_pend || !last_b);
                last_b   = win_b;
                serve_c  = c + 1;
                ack_c    = c + 2;
                free_c   = c + 3;
                cur_we   = win_b ? bus.b_we : bus.a_we;
                cur_addr = win_b ? bus.b_addr : bus.a_addr;
                if (cur_we)     ref_mem[cur_addr] = win_b ? bus.b_wdata : bus.a_wdata;
                else if (win_b) exp_b_rd = ref_mem[cur_addr];
                else            exp_a_rd = ref_mem[cur_addr];
                $display("txn rnd c=%0d %s %s addr=%0d data=%h", c, win_b ? "B" : "A",
                         cur_we ? "WR" : "RD", cur_addr, ref_mem[cur_addr]);
            end
            tick;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
